// File: rtl/rtc_burst_bus_ctrl.sv
// rtc_burst_bus_ctrl: burst read/write controller for a multiplexed-bus RTC (ADDR/GAP/DATA/GAP per register).
// Optional BCD plausibility check on read captures, enabled by defining RTC_BCD_CHECK_EN.
module rtc_burst_bus_ctrl #(
  parameter int          N_REG     = 9,
  parameter int          T_PH      = 4,
  parameter logic [7:0]  ADDR_BASE = 8'h21
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               start_wr,
  input  logic               start_rd,
  input  logic [8*N_REG-1:0] wr_data,
  output logic [8*N_REG-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic               bcd_err,
  output logic               CSO,
  output logic               ADO,
  output logic               WRO,
  output logic               RDO,
  inout  wire  [7:0]         Bus_Dato_Dir
);
  typedef enum logic [2:0] {IDLE, ADDR, GAP_A, DATA, GAP_D} state_t;
  localparam logic [3:0] LAST_PH  = 4'(T_PH - 1);
  localparam logic [3:0] LAST_IDX = 4'(N_REG - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, idx_q, idx_d, strb_q, strb_d;
  logic dir_q, dir_d, done_q, done_d, busy_q, busy_d, oe_q, oe_d;
  logic [7:0] bus_q, bus_d, wr_byte;
  logic [8*N_REG-1:0] rd_q, rd_d;
  logic last_ph, accept, cap;
  always_comb begin
    last_ph = cnt_q == LAST_PH;
    accept  = state_q == IDLE && (start_wr || start_rd);
    cap     = state_q == DATA && !dir_q && last_ph;
    state_d = state_q;
    cnt_d   = (state_q == IDLE || last_ph) ? 4'd0 : cnt_q + 4'd1;
    idx_d   = idx_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE:    if (accept) begin
        state_d = ADDR;
        dir_d   = start_wr;
        idx_d   = 4'd0;
      end
      ADDR:    state_d = last_ph ? GAP_A : ADDR;
      GAP_A:   state_d = last_ph ? DATA : GAP_A;
      DATA:    state_d = last_ph ? GAP_D : DATA;
      GAP_D:   if (last_ph) begin
        state_d = idx_q == LAST_IDX ? IDLE : ADDR;
        idx_d   = idx_q == LAST_IDX ? idx_q : idx_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    rd_d    = rd_q;
    wr_byte = 8'h00;
    for (int i = 0; i < N_REG; i++) begin
      if (cap && idx_q == 4'(i)) rd_d[8*i +: 8] = Bus_Dato_Dir;
      if (idx_d == 4'(i)) wr_byte = wr_data[8*i +: 8];
    end
    done_d = state_q == GAP_D && last_ph && idx_q == LAST_IDX;
    busy_d = state_d != IDLE;
    // Strobes {CSO,ADO,WRO,RDO} and bus drive are decoded from the next state so they are flop outputs.
    strb_d = state_d == ADDR ? 4'b0001 : state_d == DATA ? (dir_d ? 4'b0101 : 4'b0110) : 4'b1111;
    oe_d   = state_d == ADDR || (state_d == DATA && dir_d);
    bus_d  = state_d == ADDR ? ADDR_BASE + {4'd0, idx_d} : wr_byte;
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      strb_q  <= 4'b1111;
      oe_q    <= 1'b0;
      bus_q   <= 8'h00;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      strb_q  <= strb_d;
      oe_q    <= oe_d;
      bus_q   <= bus_d;
      rd_q    <= rd_d;
    end
  end
`ifdef RTC_BCD_CHECK_EN
  logic bcd_q, bcd_d;
  always_comb
    bcd_d = (accept && !start_wr) ? 1'b0
          : (cap && (Bus_Dato_Dir[7:4] > 4'd9 || Bus_Dato_Dir[3:0] > 4'd9)) ? 1'b1 : bcd_q;
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) bcd_q <= 1'b0;
    else bcd_q <= bcd_d;
  end
  assign bcd_err = bcd_q;
`else
  assign bcd_err = 1'b0;
`endif
  assign {CSO, ADO, WRO, RDO} = strb_q;
  assign Bus_Dato_Dir = oe_q ? bus_q : 8'hzz;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_q;
endmodule

// File: tb/tb_rtc_burst_bus_ctrl.sv
// tb_rtc_burst_bus_ctrl: scoreboard bench; stimulus queues expected bus phases and completion results,
// a negedge monitor pops and compares them as the DUT presents them. Bus is pulled up, so released reads 8'hFF.
module tb_rtc_burst_bus_ctrl;
  localparam int T_PH = 2;
`ifdef RTC_BCD_CHECK_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif
  logic CLK, Reset, start_wr, start_rd;
  logic [23:0] wr_data, rd_data;
  logic busy, done, bcd_err, CSO, ADO, WRO, RDO;
  logic [7:0] tb_drv;
  tri1 [7:0] bus;
  assign bus = (RDO === 1'b0) ? tb_drv : 8'hzz;
  rtc_burst_bus_ctrl #(.N_REG(3), .T_PH(T_PH), .ADDR_BASE(8'h21)) dut (
    .CLK(CLK), .Reset(Reset), .start_wr(start_wr), .start_rd(start_rd),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done), .bcd_err(bcd_err),
    .CSO(CSO), .ADO(ADO), .WRO(WRO), .RDO(RDO), .Bus_Dato_Dir(bus)
  );
  int n_cmp = 0, n_bad = 0;
  logic [31:0] expq[$];
  bit mon_en = 1'b1;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic sb(input string nm, input logic [31:0] act);
    logic [31:0] e;
    if (expq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %h, expected no event", nm, act);
    end else begin
      e = expq.pop_front();
      chk(nm, act, e);
    end
  endtask
  // Event word: [31:28] kind, [27:24] {CSO,ADO,WRO,RDO}, [23:0] value.
  logic [3:0] cur, prev_s = 4'hF;
  int run = 0, bcnt = 0;
  bit prev_busy = 1'b0;
  always @(negedge CLK) begin
    cur = {CSO, ADO, WRO, RDO};
    if (mon_en && !Reset) begin
      if (cur != prev_s) begin
        if (prev_busy) chk("phase_len", run, T_PH);
        sb("phase", {4'h1, cur, 16'h0, bus});
      end
      if (done) begin
        sb("done_busy_cycles", {4'h2, 4'h0, 24'(bcnt)});
        sb("done_rd_data", {4'h3, 4'h0, rd_data});
        sb("done_bcd_err", {4'h4, 4'h0, 23'h0, bcd_err});
      end
    end
    bcnt = busy ? bcnt + 1 : 0;
    run = (cur != prev_s) ? 1 : run + 1;
    prev_s = cur;
    prev_busy = busy;
  end
  task automatic push_burst(input bit wr, input logic [23:0] wd, input logic [23:0] exp_rd, input bit exp_bcd);
    for (int i = 0; i < 3; i++) begin
      expq.push_back({4'h1, 4'b0001, 16'h0, 8'(8'h21 + i)});
      expq.push_back({4'h1, 4'b1111, 16'h0, 8'hFF});
      expq.push_back(wr ? {4'h1, 4'b0101, 16'h0, wd[8*i +: 8]} : {4'h1, 4'b0110, 16'h0, tb_drv});
      expq.push_back({4'h1, 4'b1111, 16'h0, 8'hFF});
    end
    expq.push_back({4'h2, 4'h0, 24'd24});
    expq.push_back({4'h3, 4'h0, exp_rd});
    expq.push_back({4'h4, 4'h0, 23'h0, exp_bcd});
  endtask
  task automatic run_burst(input bit sw, input bit sr, input logic [23:0] wd, input logic [7:0] drv,
                           input logic [23:0] exp_rd, input bit exp_bcd, input int mid_rd);
    int k;
    wr_data = wd;
    tb_drv = drv;
    push_burst(sw, wd, exp_rd, exp_bcd);
    @(negedge CLK);
    start_wr = sw;
    start_rd = sr;
    @(negedge CLK);
    start_wr = 1'b0;
    start_rd = 1'b0;
    if (mid_rd > 0) begin
      repeat (mid_rd) @(negedge CLK);
      start_rd = 1'b1;
      @(negedge CLK);
      start_rd = 1'b0;
    end
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (done !== 1'b1) chk("done_timeout", {31'h0, done}, 32'h1);
    repeat (12) @(negedge CLK);
  endtask
  initial begin
    int cnt, k;
    bit seen;
    Reset = 1'b1;
    start_wr = 1'b0;
    start_rd = 1'b0;
    wr_data = 24'h0;
    tb_drv = 8'h23;
    repeat (3) @(negedge CLK);
    chk("rst_strobes", {28'h0, CSO, ADO, WRO, RDO}, 32'hF);
    chk("rst_bus_z", bus, 8'hFF);
    chk("rst_busy_done", {30'h0, busy, done}, 32'h0);
    chk("rst_bcd_err", bcd_err, 1'b0);
    chk("rst_rd_data", rd_data, 24'h0);
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    run_burst(1, 0, 24'h163A15, 8'h23, 24'h000000, 1'b0, 0);
    run_burst(0, 1, 24'h163A15, 8'h23, 24'h232323, 1'b0, 0);
    run_burst(1, 1, 24'h0F5AC3, 8'h23, 24'h232323, 1'b0, 0);
    run_burst(1, 0, 24'h998877, 8'h23, 24'h232323, 1'b0, 5);
    run_burst(0, 1, 24'h998877, 8'h3C, 24'h3C3C3C, BCD_ON, 0);
    run_burst(1, 0, 24'h010203, 8'h3C, 24'h3C3C3C, BCD_ON, 0);
    run_burst(0, 1, 24'h010203, 8'h23, 24'h232323, 1'b0, 0);
    mon_en = 1'b0;
    wr_data = 24'h445566;
    @(negedge CLK);
    start_wr = 1'b1;
    @(negedge CLK);
    start_wr = 1'b0;
    cnt = 0;
    k = 0;
    while (cnt < 3 && k < 100) begin
      @(negedge CLK);
      k++;
      if (!WRO && ADO) cnt++;
    end
    chk("abort_reached_data1", cnt, 3);
    #1 Reset = 1'b1;
    #1;
    chk("abort_strobes", {28'h0, CSO, ADO, WRO, RDO}, 32'hF);
    chk("abort_bus_z", bus, 8'hFF);
    chk("abort_busy_done", {30'h0, busy, done}, 32'h0);
    chk("abort_rd_data", rd_data, 24'h0);
    @(negedge CLK);
    Reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
